// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller: FSM states,
// special segment patterns and the active-low digit code table.
package seg7_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry k is the active-low pattern (bit6..bit0) for decimal digit k.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational BCD nibble to active-low segment pattern; non-BCD nibbles
// show a dash, and blank_i overrides everything with all segments off.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_DASH;
    if (blank_i) begin
      seg_n_o = SEG_BLANK;
    end else if (bcd_i <= 4'd9) begin
      seg_n_o = SEG_TABLE[bcd_i];
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display with
// inter-digit dead time, leading-zero blanking and frame-aligned value update.
module seven_seg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DWELL    = 1000,
  parameter int GAP      = 16,
  parameter int LZ_BLANK = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        load,
  input  logic [4*N_DIGITS-1:0]       value,
  output logic [6:0]                  seg_n,
  output logic [N_DIGITS-1:0]         an_n,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_done
);

  localparam int IW   = $clog2(N_DIGITS);
  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0]   pending_q, pending_d;
  logic [4*N_DIGITS-1:0]   shown_q, shown_d;
  logic [6:0]              seg_q, seg_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic                    fdone_q, fdone_d;
  logic                    frame_start;
  logic [N_DIGITS-1:0]     lz_mask;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic [6:0]              dec_seg;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    fdone_d     = 1'b0;
    frame_start = 1'b0;
    pending_d   = load ? value : pending_q;
    if (!en) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = S_SHOW;
          idx_d       = '0;
          cnt_d       = '0;
          frame_start = 1'b1;
        end
        S_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d       = '0;
              fdone_d     = 1'b1;
              frame_start = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // pending_d already carries a same-cycle load, giving the frame-start bypass.
    shown_d = frame_start ? pending_d : shown_q;
  end

  // Outputs are computed from next-state values so the pins line up with the
  // registered state, including going dark on the edge that enters IDLE.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (shown_d[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_run;
    end
    cur_nib = shown_d[4*int'(idx_d) +: 4];
    seg_d   = SEG_BLANK;
    an_d    = '1;
    if (state_d == S_SHOW) begin
      seg_d        = dec_seg;
      an_d[idx_d]  = 1'b0;
    end
  end

  seg7_digit_decode u_decode (
    .bcd_i   (cur_nib),
    .blank_i ((LZ_BLANK != 0) && lz_mask[idx_d]),
    .seg_n_o (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      shown_q   <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      shown_q   <= shown_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      fdone_q   <= fdone_d;
    end
  end

  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with N_DIGITS=4, DWELL=4, GAP=2.
`timescale 1ns/1ps
module tb_seven_seg_scan_ctrl;

  localparam int FRAME = 24;  // 4 digits x (4 lit + 2 dark)

  logic        clk;
  logic        reset;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  seven_seg_scan_ctrl #(
    .N_DIGITS (4),
    .DWELL    (4),
    .GAP      (2),
    .LZ_BLANK (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .value      (value),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {frame_done, digit_idx, an_n, seg_n}
  logic [13:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  bit          running = 0;
  int          t = 0;
  logic [15:0] shown_m = '0;
  logic [15:0] pending_m = '0;

  function automatic logic [6:0] code(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
    logic [15:0] upper;
    upper = v >> (4 * d);
    if (d > 0 && upper == 16'h0) return 7'h7F;
    return code(upper[3:0]);
  endfunction

  // driver: one clock of stimulus, model update, push expectation, then compare
  task automatic step(input logic ld, input logic [15:0] v, input string tag);
    logic [13:0] exp_w;
    logic [13:0] got;
    logic [3:0]  an_e;
    logic [1:0]  idx_e;
    logic [6:0]  seg_e;
    logic        fd_e;
    int          pos;
    int          d;
    load  = ld;
    value = v;
    @(posedge clk);
    if (reset) begin
      running = 0; t = 0; shown_m = '0; pending_m = '0;
    end else if (!en) begin
      running = 0;
      if (ld) pending_m = v;
    end else begin
      if (!running) begin running = 1; t = 0; end
      else t++;
      if (t % FRAME == 0) shown_m = ld ? v : pending_m;
      if (ld) pending_m = v;
    end
    pos   = t % FRAME;
    d     = pos / 6;
    an_e  = 4'hF;
    seg_e = 7'h7F;
    idx_e = running ? 2'(d) : 2'd0;
    fd_e  = running && (t > 0) && (pos == 0);
    if (running && (pos % 6) < 4) begin
      an_e[d] = 1'b0;
      seg_e   = exp_seg(shown_m, d);
    end
    exp_w = {fd_e, idx_e, an_e, seg_e};
    exp_q.push_back(exp_w);
    @(negedge clk);
    got   = {frame_done, digit_idx, an_n, seg_n};
    exp_w = exp_q.pop_front();
    checks++;
    if (got !== exp_w) begin
      errors++;
      $display("FAIL %s t=%0d: got fd=%b idx=%0d an=%b seg=%b, expected fd=%b idx=%0d an=%b seg=%b",
               tag, t, got[13], got[12:11], got[10:7], got[6:0],
               exp_w[13], exp_w[12:11], exp_w[10:7], exp_w[6:0]);
    end
    load = 1'b0;
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom_range(0, 65535)), tag);
  endtask

  // advance until the model's last sampled cycle sits at frame position p
  task automatic run_to(input int p, input string tag);
    for (int i = 0; i < 2 * FRAME && !(running && (t % FRAME) == p); i++)
      step(1'b0, 16'($urandom_range(0, 65535)), tag);
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0;
    step(1'b0, 16'h0, "reset");
    reset = 1'b0;
    idle_steps(10, "reset_dark");
  endtask

  task automatic test_scan();
    step(1'b1, 16'h1234, "scan_load");
    en = 1'b1;
    idle_steps(2 * FRAME + 1, "scan_1234");
  endtask

  task automatic test_lz();
    step(1'b1, 16'h0070, "lz_load70");
    idle_steps(2 * FRAME, "lz_0070");
    step(1'b1, 16'h0000, "lz_load0");
    idle_steps(2 * FRAME, "lz_0000");
  endtask

  task automatic test_tearfree();
    step(1'b1, 16'h1234, "tear_load1234");
    run_to(FRAME - 1, "tear_align");
    run_to(6, "tear_to_d1");
    step(1'b1, 16'h5678, "tear_load_mid");
    idle_steps(FRAME + 6, "tear_after");
    run_to(FRAME - 1, "tear_to_end");
    step(1'b1, 16'h9021, "tear_bypass");
    idle_steps(FRAME, "tear_bypass_frame");
  endtask

  task automatic test_dash();
    step(1'b1, 16'hA00F, "dash_load");
    idle_steps(2 * FRAME, "dash_A00F");
  endtask

  task automatic test_en_drop();
    step(1'b1, 16'h4321, "endrop_load");
    run_to(FRAME - 1, "endrop_align");
    run_to(13, "endrop_to_d2");
    en = 1'b0;
    idle_steps(4, "endrop_dark");
    en = 1'b1;
    idle_steps(FRAME + 2, "endrop_restart");
    run_to(8, "midreset_align");
    reset = 1'b1;
    step(1'b1, 16'h7777, "midreset");
    reset = 1'b0;
    idle_steps(FRAME + 2, "after_reset");
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    load  = 1'b0;
    value = '0;
    test_reset();
    test_scan();
    test_lz();
    test_tearfree();
    test_dash();
    test_en_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
